// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and counter widths for the PLL lock supervisor.
// Revision 1.0
`default_nettype none

package pll_sup_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RESET_PLL = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_MEASURE   = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_FAULT     = 3'd4;

  // Widths cover the default parameters with headroom (timer reaches 500000).
  localparam int TIMER_W = 20;
  localparam int WIN_W   = 16;
  localparam int EDGE_W  = 16;
  localparam int RETRY_W = 4;
  localparam int GOOD_W  = 4;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer, synchronous reset to 0.
// Revision 1.0
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for lock, verifies output frequency
// and gates the downstream reset; retries a bounded number of times before faulting.
// Revision 1.0
`default_nettype none

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 100,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int WINDOW_CYCLES       = 50000,
  parameter int EXP_COUNT           = 1000,
  parameter int TOL                 = 10,
  parameter int STABLE_WINDOWS      = 2,
  parameter int MAX_RETRIES         = 7
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        pll_clk_mon,
  output logic        pll_rst,
  output logic        sys_rst,
  output logic        pll_ready,
  output logic [15:0] freq_count,
  output logic        freq_ok,
  output logic [3:0]  retry_count,
  output logic        fault
);

  localparam logic [TIMER_W-1:0] c_rst_last     = TIMER_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_timeout_last = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [WIN_W-1:0]   c_win_last     = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [31:0]        c_cnt_lo       = (EXP_COUNT > TOL) ? 32'(EXP_COUNT - TOL) : 32'd0;
  localparam logic [31:0]        c_cnt_hi       = 32'(EXP_COUNT + TOL);
  localparam logic [RETRY_W-1:0] c_retry_max    = RETRY_W'(MAX_RETRIES);
  localparam logic [GOOD_W-1:0]  c_good_last    = GOOD_W'(STABLE_WINDOWS - 1);

  logic               w_lock;
  logic               w_mon;
  logic               r_mon_d;
  logic               w_mon_rise;
  state_t             r_state;
  state_t             w_next;
  logic               w_retry;
  logic [TIMER_W-1:0] r_timer;
  logic [WIN_W-1:0]   r_win;
  logic [EDGE_W-1:0]  r_edge;
  logic [EDGE_W-1:0]  w_edge_sum;
  logic [GOOD_W-1:0]  r_good;
  logic               w_measuring;
  logic               w_win_end;
  logic               w_win_ok;

  sync_2ff u_sync_lock (.clk(refclk), .rst(rst), .d(pll_locked),  .q(w_lock));
  sync_2ff u_sync_mon  (.clk(refclk), .rst(rst), .d(pll_clk_mon), .q(w_mon));

  assign w_mon_rise  = w_mon & ~r_mon_d;
  assign w_measuring = (r_state == ST_MEASURE) || (r_state == ST_RUN);
  assign w_win_end   = w_measuring && (r_win == c_win_last);
  assign w_edge_sum  = (r_edge == {EDGE_W{1'b1}}) ? r_edge : r_edge + EDGE_W'(w_mon_rise);
  assign w_win_ok    = ({16'd0, w_edge_sum} >= c_cnt_lo) && ({16'd0, w_edge_sum} <= c_cnt_hi);
  assign pll_rst     = (r_state == ST_RESET_PLL) || (r_state == ST_FAULT);

  // Lock loss is tested first so it wins over a coincident window result.
  always_comb begin
    w_next  = r_state;
    w_retry = 1'b0;
    case (r_state)
      ST_RESET_PLL: if (r_timer == c_rst_last) w_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_lock)                          w_next  = ST_MEASURE;
        else if (r_timer == c_timeout_last)  w_retry = 1'b1;
      end
      ST_MEASURE: begin
        if (!w_lock) w_retry = 1'b1;
        else if (w_win_end) begin
          if (!w_win_ok)                w_retry = 1'b1;
          else if (r_good == c_good_last) w_next = ST_RUN;
        end
      end
      ST_RUN:   if (!w_lock || (w_win_end && !w_win_ok)) w_retry = 1'b1;
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_RESET_PLL;
    endcase
    if (w_retry) w_next = (retry_count == c_retry_max) ? ST_FAULT : ST_RESET_PLL;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= ST_RESET_PLL;
      r_timer     <= '0;
      r_win       <= '0;
      r_edge      <= '0;
      r_good      <= '0;
      r_mon_d     <= 1'b0;
      sys_rst     <= 1'b1;
      pll_ready   <= 1'b0;
      freq_count  <= '0;
      freq_ok     <= 1'b0;
      retry_count <= '0;
      fault       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mon_d <= w_mon;

      if ((w_next != r_state) || !((r_state == ST_RESET_PLL) || (r_state == ST_WAIT_LOCK)))
        r_timer <= '0;
      else
        r_timer <= r_timer + TIMER_W'(1);

      // Counters idle at zero outside MEASURE/RUN, so entry into MEASURE starts clean.
      if (!w_measuring) begin
        r_win  <= '0;
        r_edge <= '0;
      end else if (w_win_end) begin
        r_win      <= '0;
        r_edge     <= '0;
        freq_count <= w_edge_sum;
        freq_ok    <= w_win_ok;
      end else begin
        r_win  <= r_win + WIN_W'(1);
        r_edge <= w_edge_sum;
      end

      if (r_state != ST_MEASURE)
        r_good <= '0;
      else if (w_win_end && w_win_ok)
        r_good <= r_good + GOOD_W'(1);

      if ((w_next == ST_RUN) && (r_state != ST_RUN))
        retry_count <= '0;
      else if (w_retry && (retry_count != c_retry_max))
        retry_count <= retry_count + 4'd1;

      fault     <= (w_next == ST_FAULT);
      sys_rst   <= (r_state != ST_RUN);
      pll_ready <= (r_state == ST_RUN);
    end
  end

endmodule

`default_nettype wire
